// File: rtl/cos_share_sched_pkg.sv
// Shared constants for the cosine-core sharing scheduler and its tag pipe.
// SINGLE is the float word width; COS_CORE_LAT is the latency of the attached
// cosine core (including its fix-up register). The core wrapper and this
// scheduler both take it from here, so the two always agree on the latency.
package cos_share_sched_pkg;

  localparam int SINGLE       = 32;
  localparam int COS_CORE_LAT = 17;
  localparam int COS_N_REQ    = 4;

endpackage

// File: rtl/cos_tag_pipe.sv
// Tag delay line: carries {vld, idx} of each issue alongside the cosine core
// so that the owner index arrives on the same cycle as the core result.
module cos_tag_pipe
  import cos_share_sched_pkg::*;
#(
  parameter int DEPTH = COS_CORE_LAT,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_idx,
  output logic         out_vld,
  output logic [W-1:0] out_idx
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     idx [DEPTH];

  // Shift valid and index one stage per cycle; reset drops every tag in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) idx[i] <= '0;
    end else begin
      vld    <= (vld << 1) | DEPTH'(in_vld);
      idx[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) idx[i] <= idx[i-1];
    end
  end

  assign out_vld = vld[DEPTH-1];
  assign out_idx = idx[DEPTH-1];

endmodule

// File: rtl/cos_share_sched.sv
// Time-multiplexes one pipelined cosine core among N_REQ requesters.
// Round-robin arbitration, one issue per cycle, each result routed back to
// its owner with a one-hot valid a fixed CORE_LAT+2 cycles after the grant.
//
// Handshake: requester i raises req[i] with theta[i] and holds both stable
// until grant[i] is seen (combinational, same cycle). A requester is only
// eligible while it has no result in flight (busy[i] low); busy[i] drops on
// the same edge that raises res_vld[i], so it can be re-granted in that cycle.
module cos_share_sched
  import cos_share_sched_pkg::*;
#(
  parameter int N_REQ    = COS_N_REQ,
  parameter int CORE_LAT = COS_CORE_LAT,
  parameter int IDXW     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*SINGLE-1:0] theta,
  output logic [N_REQ-1:0]        grant,
  output logic [SINGLE-1:0]       core_theta,
  output logic                    core_vld,
  input  logic [SINGLE-1:0]       core_cos,
  output logic [SINGLE-1:0]       res_cos,
  output logic [N_REQ-1:0]        res_vld,
  output logic [N_REQ-1:0]        busy,
  output logic                    idle
);

  localparam logic [IDXW:0]   N_REQ_W  = (IDXW+1)'(N_REQ);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_REQ - 1);

  logic [IDXW-1:0]  ptr;
  logic [IDXW-1:0]  grant_idx;
  logic             grant_any;
  logic [N_REQ-1:0] elig;
  logic [IDXW-1:0]  issue_idx;
  logic             tag_vld;
  logic [IDXW-1:0]  tag_idx;
  logic [N_REQ-1:0] ret_oh;
  logic [IDXW:0]    cand;

  // Round-robin search: first eligible index at or after ptr, wrapping.
  always_comb begin
    elig      = req & ~busy;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int o = 0; o < N_REQ; o++) begin
      cand = {1'b0, ptr} + (IDXW+1)'(o);
      if (cand >= N_REQ_W) cand = cand - N_REQ_W;
      if (!grant_any && elig[cand[IDXW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IDXW-1:0];
      end
    end
    grant = grant_any ? (N_REQ'(1) << grant_idx) : '0;
  end

  // Pointer moves just past the winner; it holds when nobody is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + IDXW'(1);
    end
  end

  // Issue register: the granted angle goes to the core; core_theta holds on bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_theta <= '0;
      core_vld   <= 1'b0;
      issue_idx  <= '0;
    end else begin
      core_vld <= grant_any;
      if (grant_any) begin
        core_theta <= theta[grant_idx*SINGLE +: SINGLE];
        issue_idx  <= grant_idx;
      end
    end
  end

  cos_tag_pipe #(
    .DEPTH (CORE_LAT),
    .W     (IDXW)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (core_vld),
    .in_idx  (issue_idx),
    .out_vld (tag_vld),
    .out_idx (tag_idx)
  );

  assign ret_oh = tag_vld ? (N_REQ'(1) << tag_idx) : '0;

  // Return register: capture the core output only when a tag owns it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cos <= '0;
      res_vld <= '0;
    end else begin
      res_vld <= ret_oh;
      if (tag_vld) res_cos <= core_cos;
    end
  end

  // One outstanding result per requester: set on grant, cleared on return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~ret_oh) | grant;
    end
  end

  // Every tag inside the pipe still has its owner's busy bit set, so busy,
  // the pipe output and the issue register together cover all work in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle <= 1'b1;
    end else begin
      idle <= ~|busy & ~tag_vld & ~core_vld;
    end
  end

endmodule

// File: tb/tb_cos_share_sched.sv
// Bench for cos_share_sched with a behavioural cosine core
// (delay line of CORE_LAT, cos = theta ^ 32'h0000_00FF).
module tb_cos_share_sched;
  import cos_share_sched_pkg::*;

  localparam int N    = 4;
  localparam int LAT  = 17;
  localparam int RLAT = LAT + 2;
  localparam int W    = 32 + N + 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*32-1:0]   theta;
  logic [N-1:0]      grant;
  logic [31:0]       core_theta;
  logic              core_vld;
  logic [31:0]       core_cos;
  logic [31:0]       res_cos;
  logic [N-1:0]      res_vld;
  logic [N-1:0]      busy;
  logic              idle;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [N-1:0] last_grant;
  logic [31:0]  dl [LAT];

  cos_share_sched #(.N_REQ(N), .CORE_LAT(LAT), .IDXW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .theta      (theta),
    .grant      (grant),
    .core_theta (core_theta),
    .core_vld   (core_vld),
    .core_cos   (core_cos),
    .res_cos    (res_cos),
    .res_vld    (res_vld),
    .busy       (busy),
    .idle       (idle)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural core, deliberately not reset
  always @(posedge clk) begin
    dl[0] <= core_theta;
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end
  assign core_cos = dl[LAT-1] ^ 32'h0000_00FF;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // scoreboard: invariants, result matching, expectation push on grant
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      last_grant <= '0;
    end else begin
      check_val("grant_onehot", 64'($onehot0(grant)), 64'd1);
      check_val("grant_while_busy", 64'(grant & busy), 64'd0);
      check_val("res_onehot", 64'($onehot0(res_vld)), 64'd1);
      if (res_vld != '0) begin
        if (exp_q.size() == 0) begin
          check_val("sb_unexpected", 64'(res_vld), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("sb_cycle", 64'(cyc), 64'(e[W-1 -: 32]));
          check_val("sb_owner", 64'(res_vld), 64'(e[35:32]));
          check_val("sb_data", 64'(res_cos), 64'(e[31:0]));
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q[0];
        if (e[W-1 -: 32] == 32'(cyc)) begin
          check_val("sb_missing", 64'(res_vld), 64'(e[35:32]));
          void'(exp_q.pop_front());
        end
      end
      for (int k = 0; k < N; k++) begin
        if (grant[k]) begin
          exp_q.push_back({32'(cyc + RLAT), N'(1) << k, theta[k*32 +: 32] ^ 32'h0000_00FF});
          break;
        end
      end
      last_grant <= grant;
    end
  end

  initial begin
    int n;
    rst   = 1'b1;
    req   = '0;
    theta = '0;

    // reset state
    do_reset();
    @(negedge clk);
    check_val("rst_grant", 64'(grant), 64'd0);
    check_val("rst_res_vld", 64'(res_vld), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_core_vld", 64'(core_vld), 64'd0);
    check_val("rst_core_theta", 64'(core_theta), 64'd0);
    check_val("rst_res_cos", 64'(res_cos), 64'd0);
    check_val("rst_idle", 64'(idle), 64'd1);

    // 1. single request on index 2
    tick();
    req = 4'b0100;
    theta[2*32 +: 32] = 32'h3F80_0000;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      if (c == 1) req = '0;
      @(negedge clk);
      if (c == 0) check_val("t1_grant", 64'(grant), 64'h4);
      if (c == 1) begin
        check_val("t1_core_vld", 64'(core_vld), 64'd1);
        check_val("t1_core_theta", 64'(core_theta), 64'h3F80_0000);
      end
      if (c >= 1 && c <= 18) check_val("t1_busy", 64'(busy), 64'h4);
      if (c == 5) check_val("t1_idle_low", 64'(idle), 64'd0);
      if (c == 19) begin
        check_val("t1_res_vld", 64'(res_vld), 64'h4);
        check_val("t1_res_cos", 64'(res_cos), 64'h3F80_00FF);
        check_val("t1_busy_clr", 64'(busy), 64'd0);
      end
      if (c == 20) begin
        check_val("t1_idle_back", 64'(idle), 64'd1);
        check_val("t1_res_vld_pulse", 64'(res_vld), 64'd0);
        check_val("t1_res_cos_hold", 64'(res_cos), 64'h3F80_00FF);
      end
    end

    // 2. all four requesting from reset, held high
    do_reset();
    tick();
    req = 4'hF;
    for (int i = 0; i < N; i++) theta[i*32 +: 32] = 32'h4000_0000 + 32'(i * 16 + 1);
    for (int c = 0; c <= 22; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (c < 4) check_val("t2_grant", 64'(grant), 64'(4'(1) << c));
      else if (c < 19) check_val("t2_grant_idle", 64'(grant), 64'd0);
      else begin
        check_val("t2_regrant_wrap", 64'(grant), 64'(4'(1) << (c - 19)));
        check_val("t2_res_order", 64'(res_vld), 64'(4'(1) << (c - 19)));
      end
    end
    tick();
    req = '0;
    repeat (25) tick();

    // 3. fairness with req=1010; 5. same-cycle return and re-grant of index 1
    do_reset();
    tick();
    req = 4'b1010;
    theta[1*32 +: 32] = 32'h3F00_1234;
    theta[3*32 +: 32] = 32'hBF80_5678;
    n = 0;
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) tick();
      @(negedge clk);
      if (grant != '0) begin
        check_val("t3_alternate", 64'(grant), (n % 2 == 0) ? 64'h2 : 64'h8);
        n++;
      end
      if (c == 19) begin
        check_val("t5_return", 64'(res_vld), 64'h2);
        check_val("t5_regrant", 64'(grant), 64'h2);
      end
      if (c == 38) begin
        check_val("t5_second_res", 64'(res_vld), 64'h2);
        check_val("t5_second_cos", 64'(res_cos), 64'h3F00_12CB);
      end
    end
    check_val("t3_grant_count", 64'(n), 64'd6);
    tick();
    req = '0;
    repeat (25) tick();

    // 4. reset mid-flight
    do_reset();
    tick();
    req = 4'b0111;
    for (int i = 0; i < N; i++) theta[i*32 +: 32] = 32'h3E00_0000 + 32'(i);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 3) req = '0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_val("t4_busy", 64'(busy), 64'd0);
    check_val("t4_idle", 64'(idle), 64'd1);
    check_val("t4_core_vld", 64'(core_vld), 64'd0);
    for (int c = 11; c <= 40; c++) begin
      tick();
      @(negedge clk);
      check_val("t4_no_stale", 64'(res_vld), 64'd0);
    end

    // 6. random traffic
    do_reset();
    tick();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && last_grant[i]) begin
          if ($urandom_range(0, 1) == 1) theta[i*32 +: 32] = $urandom();
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          theta[i*32 +: 32] = $urandom();
        end
      end
      tick();
    end
    req = '0;
    repeat (30) tick();
    @(negedge clk);
    check_val("sb_drain", 64'(exp_q.size()), 64'd0);
    check_val("end_idle", 64'(idle), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
